// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment scan controller.
// One shared BCD decoder is fed one digit at a time.  An all-dark guard
// interval separates digits to suppress ghosting.  Display data is double
// buffered: loads land in a shadow buffer and are committed to the active
// buffer only at frame boundaries, so a frame never mixes old and new digits.
//
// Handshake: load is a plain write strobe with an implicit ready of 1.  Every
// clk edge with load=1 is accepted, and the last write before a frame
// boundary wins.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYC     = 100000,
    parameter int GUARD_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    pending,
    output logic                    frame_done,
    output logic [0:0]              dbg_state
);

    localparam int MAX_CYC = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0] ST_ON    = 1'b0;
    localparam logic [0:0] ST_GUARD = 1'b1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] shadow_nib;
    logic [NUM_DIGITS-1:0][3:0] active_nib;
    logic [NUM_DIGITS-1:0]      shadow_dp;
    logic [NUM_DIGITS-1:0]      active_dp;

    logic [0:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    logic                  on_done;
    logic                  guard_done;
    logic                  boundary;
    logic                  commit;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;

    assign on_done    = (state == ST_ON) && (cnt == ON_LAST);
    assign guard_done = (state == ST_GUARD) && (cnt == GUARD_LAST);
    // The frame starts on the guard-to-on step that wraps back to digit 0.
    assign boundary   = guard_done && (idx == IDX_LAST);
    assign commit     = boundary && pending;
    assign dbg_state  = state;

    // Scan sequencer: alternate ON and GUARD, and advance the digit after each guard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_GUARD;
            idx        <= IDX_LAST;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (state == ST_ON) begin
                if (on_done) begin
                    state <= ST_GUARD;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                if (guard_done) begin
                    state <= ST_ON;
                    cnt   <= '0;
                    idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Double buffer: load writes the shadow, and the frame boundary copies shadow to active.
    // On a simultaneous load and commit, active takes the old shadow and the
    // new data stays pending until the next boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_nib <= '0;
            shadow_dp  <= '0;
            active_nib <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (commit) begin
                active_nib <= shadow_nib;
                active_dp  <= shadow_dp;
            end
            if (load) begin
                shadow_nib <= din;
                shadow_dp  <= dp_in;
                pending    <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero blanking: digit i>=1 is blanked when it and every digit above it are zero.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (active_nib[i] == 4'd0);
            blank[i]   = blank_lz && zero_above;
        end
    end

    // Output decode from registered state only, so there is no extra pipeline stage.
    always_comb begin
        an      = '1;
        dp      = 1'b1;
        bcd_out = active_nib[idx];
        if ((state == ST_ON) && !blank[idx]) begin
            an[idx] = 1'b0;
            dp      = ~active_dp[idx];
        end
    end

endmodule
